datapath_controller: RTL and testbench



---
 rtl/datapath_controller_if.sv | 36 +++
 rtl/datapath_controller.sv | 151 +++++++++++++++
 tb/tb_datapath_controller.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/datapath_controller_if.sv
// Handshake and control bundle between the instruction sequencer and its fetch side / datapath.
// The fetch side drives s/load/in and the sequencer drives everything else.
interface datapath_controller_if #(
    parameter int WIDTH = 16
);
    logic             s;
    logic             load;
    logic [15:0]      in;
    logic             w;
    logic [2:0]       readnum;
    logic [2:0]       writenum;
    logic             write;
    logic             vsel;
    logic             loada;
    logic             loadb;
    logic             loadc;
    logic             loads;
    logic             asel;
    logic [1:0]       shift;
    logic [1:0]       ALUop;
    logic [WIDTH-1:0] sximm8;
    logic             illegal;
    logic             halted;

    modport master (
        output s, load, in,
        input  w, readnum, writenum, write, vsel, loada, loadb, loadc, loads,
               asel, shift, ALUop, sximm8, illegal, halted
    );

    modport slave (
        input  s, load, in,
        output w, readnum, writenum, write, vsel, loada, loadb, loadc, loads,
               asel, shift, ALUop, sximm8, illegal, halted
    );
endinterface

// File: rtl/datapath_controller.sv
// Multi-cycle sequencer: latches one instruction, then steps the datapath (MOVI 3, MOV/CMP 5, ALU 6 cycles).
// No backpressure: w=1 only in WAIT; CTRL_ILLEGAL_TRAP_EN makes illegal opcodes halt until reset.
module datapath_controller #(
    parameter int WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    datapath_controller_if.slave  bus
);
    typedef enum logic [2:0] {
        S_WAIT, S_DECODE, S_WRITE_IMM, S_GET_A, S_GET_B, S_EXEC,
`ifdef CTRL_ILLEGAL_TRAP_EN
        S_WRITE_REG, S_HALT
`else
        S_WRITE_REG
`endif
    } state_t;

    typedef struct packed {
        logic       w;
        logic [2:0] readnum;
        logic [2:0] writenum;
        logic       write;
        logic       vsel;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       asel;
        logic [1:0] shift;
        logic [1:0] alu_op;
        logic       illegal;
        logic       halted;
    } ctrl_t;

    state_t      state_q, state_d;
    logic [15:0] ir_q, ir_d;
    ctrl_t       ctrl_q, ctrl_d;

    function automatic logic is_movi(logic [15:0] ir);
        return (ir[15:13] == 3'b110) && (ir[12:11] == 2'b10);
    endfunction

    function automatic logic is_mov(logic [15:0] ir);
        return (ir[15:13] == 3'b110) && (ir[12:11] == 2'b00);
    endfunction

    function automatic logic is_alu(logic [15:0] ir);
        return ir[15:13] == 3'b101;
    endfunction

    // Outputs are a pure function of (state, IR); registering this of the next
    // state gives Moore timing with glitch-free flop outputs.
    function automatic ctrl_t decode(state_t st, logic [15:0] ir);
        ctrl_t c;
        c = '0;
        case (st)
            S_WAIT:      c.w = 1'b1;
            S_DECODE:    c.illegal = !(is_movi(ir) || is_mov(ir) || is_alu(ir));
            S_WRITE_IMM: begin
                c.write    = 1'b1;
                c.writenum = ir[10:8];
                c.vsel     = 1'b1;
            end
            S_GET_A: begin
                c.readnum = ir[10:8];
                c.loada   = 1'b1;
            end
            S_GET_B: begin
                c.readnum = ir[2:0];
                c.loadb   = 1'b1;
                c.shift   = ir[4:3];
            end
            S_EXEC: begin
                c.shift  = ir[4:3];
                c.alu_op = is_alu(ir) ? ir[12:11] : 2'b00;
                c.asel   = !is_alu(ir);
                c.loads  = is_alu(ir);
                c.loadc  = !(is_alu(ir) && ir[12:11] == 2'b01);
            end
            S_WRITE_REG: begin
                c.write    = 1'b1;
                c.writenum = ir[7:5];
            end
`ifdef CTRL_ILLEGAL_TRAP_EN
            S_HALT:      c.halted = 1'b1;
`endif
            default:     c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        case (state_q)
            S_WAIT: begin
                if (bus.load) ir_d = bus.in;
                if (bus.s) state_d = S_DECODE;
            end
            S_DECODE: begin
                if (is_movi(ir_q))     state_d = S_WRITE_IMM;
                else if (is_mov(ir_q)) state_d = S_GET_B;
                else if (is_alu(ir_q)) state_d = S_GET_A;
`ifdef CTRL_ILLEGAL_TRAP_EN
                else                   state_d = S_HALT;
`else
                else                   state_d = S_WAIT;
`endif
            end
            S_WRITE_IMM: state_d = S_WAIT;
            S_GET_A:     state_d = S_GET_B;
            S_GET_B:     state_d = S_EXEC;
            S_EXEC:      state_d = (is_alu(ir_q) && ir_q[12:11] == 2'b01) ? S_WAIT : S_WRITE_REG;
            S_WRITE_REG: state_d = S_WAIT;
`ifdef CTRL_ILLEGAL_TRAP_EN
            S_HALT:      state_d = S_HALT;
`endif
            default:     state_d = S_WAIT;
        endcase
        ctrl_d = decode(state_d, ir_d);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_WAIT;
            ir_q    <= '0;
            ctrl_q  <= decode(S_WAIT, 16'h0000);
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign bus.w        = ctrl_q.w;
    assign bus.readnum  = ctrl_q.readnum;
    assign bus.writenum = ctrl_q.writenum;
    assign bus.write    = ctrl_q.write;
    assign bus.vsel     = ctrl_q.vsel;
    assign bus.loada    = ctrl_q.loada;
    assign bus.loadb    = ctrl_q.loadb;
    assign bus.loadc    = ctrl_q.loadc;
    assign bus.loads    = ctrl_q.loads;
    assign bus.asel     = ctrl_q.asel;
    assign bus.shift    = ctrl_q.shift;
    assign bus.ALUop    = ctrl_q.alu_op;
    assign bus.illegal  = ctrl_q.illegal;
    assign bus.halted   = ctrl_q.halted;
    assign bus.sximm8   = {{(WIDTH-8){ir_q[7]}}, ir_q[7:0]};
endmodule

// File: tb/tb_datapath_controller.sv
// Directed + random bench for datapath_controller; per-cycle expected outputs queued at issue, popped each cycle.
module tb_datapath_controller;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    datapath_controller_if #(.WIDTH(16)) bus ();
    datapath_controller #(.WIDTH(16)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct packed {
        logic        w;
        logic [2:0]  readnum;
        logic [2:0]  writenum;
        logic        write;
        logic        vsel;
        logic        loada;
        logic        loadb;
        logic        loadc;
        logic        loads;
        logic        asel;
        logic [1:0]  shift;
        logic [1:0]  aluop;
        logic        illegal;
        logic        halted;
        logic [15:0] sximm8;
    } obs_t;

    obs_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    function automatic obs_t sample();
        obs_t o;
        o.w = bus.w;           o.readnum = bus.readnum; o.writenum = bus.writenum;
        o.write = bus.write;   o.vsel = bus.vsel;       o.loada = bus.loada;
        o.loadb = bus.loadb;   o.loadc = bus.loadc;     o.loads = bus.loads;
        o.asel = bus.asel;     o.shift = bus.shift;     o.aluop = bus.ALUop;
        o.illegal = bus.illegal; o.halted = bus.halted; o.sximm8 = bus.sximm8;
        return o;
    endfunction

    function automatic obs_t idle(logic [15:0] ir, logic w);
        obs_t o;
        o = '0;
        o.w = w;
        o.sximm8 = {{8{ir[7]}}, ir[7:0]};
        return o;
    endfunction

    task automatic check(string tag, obs_t exp);
        obs_t o;
        o = sample();
        tests++;
        assert (o === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, o, exp);
        end
    endtask

    // Expected outputs for every cycle after the start edge, up to and including the return to WAIT.
    task automatic push_model(logic [15:0] ir);
        obs_t base, o;
        logic alu, movi, mov, legal, cmp;
        movi  = ir[15:13] == 3'b110 && ir[12:11] == 2'b10;
        mov   = ir[15:13] == 3'b110 && ir[12:11] == 2'b00;
        alu   = ir[15:13] == 3'b101;
        cmp   = alu && ir[12:11] == 2'b01;
        legal = movi || mov || alu;
        base  = idle(ir, 1'b0);
        o = base; o.illegal = !legal; exp_q.push_back(o);
        if (movi) begin
            o = base; o.write = 1; o.writenum = ir[10:8]; o.vsel = 1; exp_q.push_back(o);
        end else if (legal) begin
            if (alu) begin
                o = base; o.readnum = ir[10:8]; o.loada = 1; exp_q.push_back(o);
            end
            o = base; o.readnum = ir[2:0]; o.loadb = 1; o.shift = ir[4:3]; exp_q.push_back(o);
            o = base; o.shift = ir[4:3]; o.aluop = alu ? ir[12:11] : 2'b00;
            o.asel = mov; o.loads = alu; o.loadc = !cmp; exp_q.push_back(o);
            if (!cmp) begin
                o = base; o.write = 1; o.writenum = ir[7:5]; exp_q.push_back(o);
            end
        end
`ifdef CTRL_ILLEGAL_TRAP_EN
        if (!legal) begin
            for (int i = 0; i < 4; i++) begin
                o = base; o.halted = 1; exp_q.push_back(o);
            end
            return;
        end
`endif
        exp_q.push_back(idle(ir, 1'b1));
    endtask

    // Called at a negedge with the DUT in WAIT; returns at the negedge of the final expected cycle.
    task automatic run(string tag, logic [15:0] ir, bit noise);
        obs_t e;
        bus.in = ir; bus.load = 1'b1; bus.s = 1'b1;
        push_model(ir);
        @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check(tag, e);
            if (exp_q.size() > 0) begin
                bus.in   = noise ? 16'($urandom) : 16'h0000;
                bus.load = noise;
                bus.s    = noise;
                @(negedge clk);
            end else begin
                bus.load = 1'b0;
                bus.s    = 1'b0;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ir;
        reset = 1'b1; bus.s = 1'b0; bus.load = 1'b0; bus.in = 16'h0000;
        #12;
        check("reset", idle(16'h0000, 1'b1));
        @(negedge clk); reset = 1'b0;
        @(negedge clk);
        check("idle", idle(16'h0000, 1'b1));

        bus.in = 16'h0080; bus.load = 1'b1;
        @(negedge clk); bus.load = 1'b0;
        check("load_only", idle(16'h0080, 1'b1));
        @(negedge clk);
        check("wait_hold", idle(16'h0080, 1'b1));

        run("movi", 16'hD2F6, 1'b0);
        run("add_lsl", 16'hA0AB, 1'b1);
        run("cmp", 16'hA901, 1'b0);
        run("mov_reg", 16'hC0E4, 1'b0);
        run("mvn", 16'hB8EA, 1'b1);
        run("and", 16'hB3B2, 1'b0);

        for (int i = 0; i < 20; i++) begin
            case ($urandom_range(2, 0))
                0:       ir = {3'b110, 2'b10, 11'($urandom)};
                1:       ir = {3'b110, 2'b00, 11'($urandom)};
                default: ir = {3'b101, 13'($urandom)};
            endcase
            run("random", ir, 1'($urandom));
        end

        // Reset while ADD sits in EXEC: the pending write-back must never appear.
        bus.in = 16'hA0AB; bus.load = 1'b1; bus.s = 1'b1;
        @(negedge clk); bus.load = 1'b0; bus.s = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_mid_exec", idle(16'h0000, 1'b1));
        @(negedge clk); reset = 1'b0;
        @(negedge clk);
        check("post_reset", idle(16'h0000, 1'b1));

`ifdef CTRL_ILLEGAL_TRAP_EN
        run("trap", 16'hE000, 1'b1);
        reset = 1'b1;
        #1;
        check("trap_reset", idle(16'h0000, 1'b1));
        @(negedge clk); reset = 1'b0;
        @(negedge clk);
        run("after_trap", 16'hD2F6, 1'b0);
`else
        run("illegal_e000", 16'hE000, 1'b0);
        run("illegal_c800", 16'hC800, 1'b0);
        run("after_illegal", 16'hD2F6, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
